draw_obstacle_ctl: RTL and testbench
====================================

DRAW_OBSTACLE_CTL -- requirements
Module: draw_obstacle_ctl

Interface
REQ-001 Parameter MOVE_DIV, default 200000; clock cycles per obstacle move step (5 ms at 40 MHz).
REQ-002 Parameter OBST_W, default 60; obstacle width in pixels.
REQ-003 Parameter GAP_H, default 150; vertical gap height in pixels.
REQ-004 clk  in  1  system clock, 40 MHz; all logic on rising edge; one clock only.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 y_from_draw_rect  in  12  player rectangle top y, unsigned pixels.
REQ-007 endgame  out  1  collision flag, sticky until reset.
REQ-008 obstacle_xpos_1  out  12  obstacle left edge x, unsigned.
REQ-009 obstacle_ypos_1  out  12  gap top y (bottom edge of upper pillar).
REQ-010 obstacle_ypos_2  out  12  gap bottom y (top edge of lower pillar).

Function
REQ-011 Fixed constants: SCREEN_W=800, SCREEN_H=600, PLAYER_X=100, PLAYER_W=50, PLAYER_H=50, GAP_MIN=100.
REQ-012 Tick counter shall count 0..MOVE_DIV-1 and assert a one-cycle step pulse when it wraps from MOVE_DIV-1 to 0.
REQ-013 On a step with endgame=0 and obstacle_xpos_1>0, obstacle_xpos_1 shall decrement by 1.
REQ-014 On a step with endgame=0 and obstacle_xpos_1==0, obstacle_xpos_1 shall reload to SCREEN_W, and new gap values shall be loaded in the same cycle.
REQ-015 New gap: obstacle_ypos_1 = GAP_MIN + LFSR[7:0], where the LFSR is the current value; obstacle_ypos_2 = obstacle_ypos_1 + GAP_H; range is 101..355 / 251..505.
REQ-016 LFSR shall be 8-bit Fibonacci with taps x^8+x^6+x^5+x^4+1, shifting every clock, never zero.
REQ-017 obstacle_ypos_2 shall always equal obstacle_ypos_1 + GAP_H.
REQ-018 Horizontal overlap is true when (PLAYER_X+PLAYER_W > obstacle_xpos_1) and (PLAYER_X < obstacle_xpos_1+OBST_W); the comparison uses 13-bit arithmetic with no wrap.
REQ-019 Collision shall be true when overlap && (y_from_draw_rect < obstacle_ypos_1 || y_from_draw_rect+PLAYER_H > obstacle_ypos_2), or when y_from_draw_rect+PLAYER_H >= SCREEN_H, evaluated on registered positions.
REQ-020 endgame shall assert on the clock edge after collision is true (1-cycle latency) and stay 1 until rst.
REQ-021 While endgame=1, all positions, the tick counter and the LFSR shall freeze.
REQ-022 Boundary conditions at overlap edges: touching exactly (y == ypos_1, or y+PLAYER_H == ypos_2) is not a collision.
REQ-023 If a step and a collision occur in the same cycle, the step applies and endgame is set together with it.

Reset
REQ-024 On rst=1 at a clock edge: obstacle_xpos_1=800, obstacle_ypos_1=225, obstacle_ypos_2=375, endgame=0, tick counter=0, LFSR=8'hA5.
REQ-025 rst asserted mid-operation, including while endgame=1, shall restore the REQ-024 values on the next edge with no other effect.

Structure
REQ-026 Package obstacle_pkg shall hold SCREEN_W, SCREEN_H, PLAYER_X, PLAYER_W, PLAYER_H, GAP_MIN, and the reset constants.
REQ-027 The LFSR shall be a sub-module named obstacle_lfsr, with ports clk, rst, en and out[7:0].
REQ-028 All outputs shall be registered, with no combinational output paths.

Verification (bench overrides MOVE_DIV=4)
REQ-029 Reset check: rst for 2 cycles with y=300 -> xpos=800, ypos_1=225, ypos_2=375, endgame=0.
REQ-030 Movement: y=250 inside the gap -> xpos decrements 1 every 4 cycles, e.g. xpos=790 after 40 cycles post-reset.
REQ-031 Wrap: run until xpos=0, keeping y inside the gap -> next step gives xpos=800, ypos_1 in 101..355, ypos_2 = ypos_1+150.
REQ-032 Collision: y=300, where y+50=350 is within 375 -> no endgame; then y=100 while xpos=120 -> endgame=1 one cycle later, and xpos frozen thereafter.
REQ-033 Floor: y=550 -> endgame=1 within 2 cycles regardless of xpos.
REQ-034 Edge and recovery: y=225 with overlap -> no endgame; rst during endgame=1 -> endgame=0 and xpos=800 next cycle.

Source files
------------

// File: rtl/obstacle_pkg.sv
// Shared screen/player geometry and reset values for the obstacle controller.
package obstacle_pkg;

  localparam int SCREEN_W = 800;
  localparam int SCREEN_H = 600;
  localparam int PLAYER_X = 100;
  localparam int PLAYER_W = 50;
  localparam int PLAYER_H = 50;
  localparam int GAP_MIN  = 100;

  localparam logic [11:0] RST_XPOS   = 12'd800;
  localparam logic [11:0] RST_YPOS_1 = 12'd225;
  localparam logic [11:0] RST_YPOS_2 = 12'd375;
  localparam logic [7:0]  RST_LFSR   = 8'hA5;

  // Zero-extend a pixel coordinate so sums never wrap in comparisons
  function automatic logic [12:0] ext13(input logic [11:0] v);
    return {1'b0, v};
  endfunction

endpackage

// File: rtl/obstacle_lfsr.sv
// 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) used to pick each new gap position.
module obstacle_lfsr
  import obstacle_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic [7:0] out
);

  // Nonzero seed plus a primitive polynomial keeps the state out of all-zeros
  always_ff @(posedge clk) begin
    if (rst)
      out <= RST_LFSR;
    else if (en)
      out <= {out[6:0], out[7] ^ out[5] ^ out[4] ^ out[3]};
  end

endmodule

// File: rtl/draw_obstacle_ctl.sv
// Scrolls a gapped pillar obstacle leftwards and latches a sticky collision flag.
module draw_obstacle_ctl
  import obstacle_pkg::*;
#(
  parameter int MOVE_DIV = 200000,
  parameter int OBST_W   = 60,
  parameter int GAP_H    = 150
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] y_from_draw_rect,
  output logic        endgame,
  output logic [11:0] obstacle_xpos_1,
  output logic [11:0] obstacle_ypos_1,
  output logic [11:0] obstacle_ypos_2
);

  localparam int TICK_W = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(MOVE_DIV - 1);

  logic [TICK_W-1:0] tick;
  logic [7:0]        lfsr;
  logic              step;
  logic              overlap;
  logic              collision;
  logic [12:0]       player_bot;

  obstacle_lfsr u_lfsr (
    .clk (clk),
    .rst (rst),
    .en  (!endgame),
    .out (lfsr)
  );

  assign step = (tick == TICK_MAX) && !endgame;

  always_ff @(posedge clk) begin
    if (rst)
      tick <= '0;
    else if (!endgame)
      tick <= (tick == TICK_MAX) ? '0 : tick + 1'b1;
  end

  // Reaching the left edge respawns the obstacle on the right with a fresh gap
  always_ff @(posedge clk) begin
    if (rst) begin
      obstacle_xpos_1 <= RST_XPOS;
      obstacle_ypos_1 <= RST_YPOS_1;
      obstacle_ypos_2 <= RST_YPOS_2;
    end else if (step) begin
      if (obstacle_xpos_1 != 12'd0) begin
        obstacle_xpos_1 <= obstacle_xpos_1 - 12'd1;
      end else begin
        obstacle_xpos_1 <= 12'(SCREEN_W);
        obstacle_ypos_1 <= 12'(GAP_MIN) + {4'd0, lfsr};
        obstacle_ypos_2 <= 12'(GAP_MIN) + {4'd0, lfsr} + 12'(GAP_H);
      end
    end
  end

  always_comb begin
    overlap    = (13'(PLAYER_X + PLAYER_W) > ext13(obstacle_xpos_1)) &&
                 (13'(PLAYER_X) < ext13(obstacle_xpos_1) + 13'(OBST_W));
    player_bot = ext13(y_from_draw_rect) + 13'(PLAYER_H);
    collision  = (overlap && ((y_from_draw_rect < obstacle_ypos_1) ||
                              (player_bot > ext13(obstacle_ypos_2)))) ||
                 (player_bot >= 13'(SCREEN_H));
  end

  always_ff @(posedge clk) begin
    if (rst)
      endgame <= 1'b0;
    else if (collision)
      endgame <= 1'b1;
  end

endmodule

// File: tb/tb_draw_obstacle_ctl.sv
// Directed bench: stimulus queues expected snapshots, a negedge monitor pops and compares them.
module tb_draw_obstacle_ctl;

  typedef struct {
    string       name;
    bit          gap_range;
    logic [11:0] x;
    logic [11:0] y1;
    logic [11:0] y2;
    logic        endg;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] y_from_draw_rect = 12'd300;
  logic        endgame;
  logic [11:0] obstacle_xpos_1, obstacle_ypos_1, obstacle_ypos_2;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  draw_obstacle_ctl #(.MOVE_DIV(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .y_from_draw_rect (y_from_draw_rect),
    .endgame          (endgame),
    .obstacle_xpos_1  (obstacle_xpos_1),
    .obstacle_ypos_1  (obstacle_ypos_1),
    .obstacle_ypos_2  (obstacle_ypos_2)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic r, input logic [11:0] y, input int cycles);
    rst = r;
    y_from_draw_rect = y;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [11:0] x, input logic [11:0] y1,
                             input logic [11:0] y2, input logic endg);
    exp_t e;
    e.name = name; e.gap_range = 1'b0;
    e.x = x; e.y1 = y1; e.y2 = y2; e.endg = endg;
    exp_q.push_back(e);
  endtask

  task automatic checkGap(input string name, input logic [11:0] x);
    exp_t e;
    e.name = name; e.gap_range = 1'b1;
    e.x = x; e.y1 = '0; e.y2 = '0; e.endg = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic compareField(input string name, input string field, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("[TB] FAIL %s.%s: got %0d, expected %0d", name, field, act, req);
    end
  endtask

  // Monitor: snapshots are taken mid-cycle, well away from the rising edge
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      compareField(e.name, "xpos", int'(obstacle_xpos_1), int'(e.x));
      compareField(e.name, "endgame", int'(endgame), int'(e.endg));
      if (e.gap_range) begin
        checks++;
        if (obstacle_ypos_1 < 12'd101 || obstacle_ypos_1 > 12'd355) begin
          errors++;
          $display("[TB] FAIL %s.ypos_1_range: got %0d, expected 101..355", e.name, obstacle_ypos_1);
        end
        compareField(e.name, "ypos_2_rel", int'(obstacle_ypos_2), int'(obstacle_ypos_1) + 150);
      end else begin
        compareField(e.name, "ypos_1", int'(obstacle_ypos_1), int'(e.y1));
        compareField(e.name, "ypos_2", int'(obstacle_ypos_2), int'(e.y2));
      end
    end
  end

  initial begin
    applyStimulus(1'b1, 12'd300, 2);
    checkOutput("reset", 800, 225, 375, 1'b0);

    applyStimulus(1'b0, 12'd250, 4);
    checkOutput("first_step", 799, 225, 375, 1'b0);
    applyStimulus(1'b0, 12'd250, 36);
    checkOutput("move_40", 790, 225, 375, 1'b0);
    applyStimulus(1'b0, 12'd250, 3160);
    checkOutput("at_zero", 0, 225, 375, 1'b0);
    applyStimulus(1'b0, 12'd250, 4);
    checkGap("wrap", 800);

    applyStimulus(1'b1, 12'd300, 1);
    checkOutput("reset2", 800, 225, 375, 1'b0);
    applyStimulus(1'b0, 12'd300, 2680);
    checkOutput("overlap_in_gap", 130, 225, 375, 1'b0);
    applyStimulus(1'b0, 12'd300, 40);
    checkOutput("pre_collision", 120, 225, 375, 1'b0);
    applyStimulus(1'b0, 12'd100, 1);
    checkOutput("collision", 120, 225, 375, 1'b1);
    applyStimulus(1'b0, 12'd100, 20);
    checkOutput("frozen", 120, 225, 375, 1'b1);

    applyStimulus(1'b1, 12'd100, 1);
    checkOutput("reset_from_endgame", 800, 225, 375, 1'b0);
    applyStimulus(1'b0, 12'd549, 3);
    checkOutput("floor_minus_one", 800, 225, 375, 1'b0);
    applyStimulus(1'b0, 12'd550, 1);
    checkOutput("floor_with_step", 799, 225, 375, 1'b1);
    applyStimulus(1'b0, 12'd550, 8);
    checkOutput("floor_frozen", 799, 225, 375, 1'b1);

    applyStimulus(1'b1, 12'd225, 1);
    checkOutput("reset3", 800, 225, 375, 1'b0);
    applyStimulus(1'b0, 12'd225, 2800);
    checkOutput("top_edge_touch", 100, 225, 375, 1'b0);
    applyStimulus(1'b0, 12'd325, 2);
    checkOutput("bottom_edge_touch", 100, 225, 375, 1'b0);
    applyStimulus(1'b0, 12'd326, 1);
    checkOutput("bottom_edge_hit", 100, 225, 375, 1'b1);

    applyStimulus(1'b1, 12'd300, 1);
    checkOutput("final_reset", 800, 225, 375, 1'b0);
    applyStimulus(1'b0, 12'd300, 2);

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
